// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, control bundle and helpers for the five-stage MIPS pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TIME_W = 2;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // A Tuse no Tnew can exceed: the operand is not read at all
    localparam logic [TIME_W-1:0] TUSE_NONE = TIME_W'(3);

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC8  = 2'b10,
        WB_HILO = 2'b11
    } wb_sel_t;

    typedef struct packed {
        alu_op_t            alu_op;
        logic               alu_src;
        logic               md_start;
        md_op_t             md_op;
        logic               mem_write;
        logic               reg_write;
        wb_sel_t            wb_sel;
        logic [REG_W-1:0]   wa;
        logic [TIME_W-1:0]  tnew;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam ctrl_t CTRL_ZERO = '0;

    // True when a D-stage source must wait for the result of a later stage
    function automatic logic raw_hit(
        input logic [REG_W-1:0]  src,
        input logic [TIME_W-1:0] tuse,
        input logic              wr,
        input logic [REG_W-1:0]  wa,
        input logic [TIME_W-1:0] tnew
    );
        return wr && (wa != '0) && (wa == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational D-stage decode: control bundle, D-stage flow controls and hazard timing.
module pipe_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0]        instr,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [TIME_W-1:0]  tuse_rs,
    output logic [TIME_W-1:0]  tuse_rt,
    output logic               md_use,
    output logic               branch,
    output logic               jump,
    output logic               jr,
    output logic               link,
    output logic [1:0]         ext_op
);

    logic [5:0]       op;
    logic [5:0]       fn;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] dst;
    ctrl_t            b;
    logic             unused_shamt;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        b       = CTRL_ZERO;
        dst     = '0;
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        md_use  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        jr      = 1'b0;
        link    = 1'b0;
        ext_op  = EXT_ZERO;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                        b.reg_write = 1'b1;
                        b.tnew      = TIME_W'(1);
                        dst         = rd;
                        tuse_rs     = TIME_W'(1);
                        tuse_rt     = TIME_W'(1);
                        case (fn)
                            FN_SUBU: b.alu_op = ALU_SUB;
                            FN_AND:  b.alu_op = ALU_AND;
                            FN_OR:   b.alu_op = ALU_OR;
                            FN_SLT:  b.alu_op = ALU_SLT;
                            default: b.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_JR: begin
                        jr      = 1'b1;
                        tuse_rs = TIME_W'(0);
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        md_use     = 1'b1;
                        b.md_start = 1'b1;
                        b.md_op    = md_op_t'({1'b0, fn[1:0]});
                        tuse_rs    = TIME_W'(1);
                        tuse_rt    = TIME_W'(1);
                    end
                    FN_MTHI, FN_MTLO: begin
                        md_use     = 1'b1;
                        b.md_start = 1'b1;
                        b.md_op    = (fn == FN_MTHI) ? MD_MTHI : MD_MTLO;
                        tuse_rs    = TIME_W'(1);
                    end
                    FN_MFHI, FN_MFLO: begin
                        md_use      = 1'b1;
                        b.reg_write = 1'b1;
                        b.wb_sel    = WB_HILO;
                        b.tnew      = TIME_W'(1);
                        dst         = rd;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                b.reg_write = 1'b1;
                b.alu_op    = ALU_ADD;
                b.alu_src   = 1'b1;
                b.wb_sel    = WB_MEM;
                b.tnew      = TIME_W'(2);
                dst         = rt;
                ext_op      = EXT_SIGN;
                tuse_rs     = TIME_W'(1);
            end
            OP_SW: begin
                b.mem_write = 1'b1;
                b.alu_op    = ALU_ADD;
                b.alu_src   = 1'b1;
                ext_op      = EXT_SIGN;
                tuse_rs     = TIME_W'(1);
                tuse_rt     = TIME_W'(2);
            end
            OP_BEQ: begin
                branch  = 1'b1;
                ext_op  = EXT_SIGN;
                tuse_rs = TIME_W'(0);
                tuse_rt = TIME_W'(0);
            end
            OP_ORI: begin
                b.reg_write = 1'b1;
                b.alu_op    = ALU_OR;
                b.alu_src   = 1'b1;
                b.tnew      = TIME_W'(1);
                dst         = rt;
                tuse_rs     = TIME_W'(1);
            end
            OP_LUI: begin
                b.reg_write = 1'b1;
                b.alu_op    = ALU_OR;
                b.alu_src   = 1'b1;
                b.tnew      = TIME_W'(1);
                dst         = rt;
                ext_op      = EXT_LUI;
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump        = 1'b1;
                link        = 1'b1;
                b.reg_write = 1'b1;
                b.wb_sel    = WB_PC8;
                dst         = REG_W'(31);
            end
            default: ;
        endcase
        // Writes to $0 are dropped so they can never cause a hazard
        if (b.reg_write && (dst != '0)) begin
            b.wa = dst;
        end else begin
            b.reg_write = 1'b0;
            b.tnew      = '0;
        end
    end

    assign ctrl = b;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: decodes D, carries the bundle through E/M/W, and raises stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        branch_d,
    output logic        jump_d,
    output logic        jr_d,
    output logic        link_d,
    output logic [1:0]  ext_op_d,
    output logic [2:0]  alu_op_e,
    output logic        alu_src_e,
    output logic        md_start_e,
    output logic [2:0]  md_op_e,
    output logic        mem_write_m,
    output logic        reg_write_w,
    output logic [1:0]  wb_sel_w,
    output logic [4:0]  wa_w,
    output logic        stall,
    output logic        md_busy
);

    ctrl_t             ctrl_d;
    ctrl_t             e_q;
    ctrl_t             m_q;
    ctrl_t             w_q;
    logic [TIME_W-1:0] tuse_rs;
    logic [TIME_W-1:0] tuse_rt;
    logic [TIME_W-1:0] tnew_m;
    logic              md_use_d;
    logic              hazard_stall;
    logic              md_stall;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  md_lat;
    logic [REG_W-1:0]  rs_d;
    logic [REG_W-1:0]  rt_d;
    logic              unused_w;

    pipe_decode u_decode (
        .instr   (instr_d),
        .ctrl    (ctrl_d),
        .tuse_rs (tuse_rs),
        .tuse_rt (tuse_rt),
        .md_use  (md_use_d),
        .branch  (branch_d),
        .jump    (jump_d),
        .jr      (jr_d),
        .link    (link_d),
        .ext_op  (ext_op_d)
    );

    assign rs_d = instr_d[25:21];
    assign rt_d = instr_d[20:16];

    // Producer in M is one stage closer to its result
    assign tnew_m = (m_q.tnew == '0) ? '0 : m_q.tnew - TIME_W'(1);

    assign hazard_stall = raw_hit(rs_d, tuse_rs, e_q.reg_write, e_q.wa, e_q.tnew)
                       || raw_hit(rt_d, tuse_rt, e_q.reg_write, e_q.wa, e_q.tnew)
                       || raw_hit(rs_d, tuse_rs, m_q.reg_write, m_q.wa, tnew_m)
                       || raw_hit(rt_d, tuse_rt, m_q.reg_write, m_q.wa, tnew_m);

    assign md_busy  = (cnt_q != '0);
    assign md_stall = md_use_d && (md_busy || e_q.md_start);
    assign stall    = hazard_stall || md_stall;

    always_comb begin
        md_lat = '0;
        case (e_q.md_op)
            MD_MULT, MD_MULTU: md_lat = CNT_W'(MULT_LAT);
            MD_DIV, MD_DIVU:   md_lat = CNT_W'(DIV_LAT);
            default:           md_lat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q   <= CTRL_ZERO;
            m_q   <= CTRL_ZERO;
            w_q   <= CTRL_ZERO;
            cnt_q <= '0;
        end else begin
            e_q <= stall ? CTRL_ZERO : ctrl_d;
            m_q <= e_q;
            w_q <= m_q;
            if (e_q.md_start) begin
                cnt_q <= md_lat;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign alu_op_e    = e_q.alu_op;
    assign alu_src_e   = e_q.alu_src;
    assign md_start_e  = e_q.md_start;
    assign md_op_e     = e_q.md_op;
    assign mem_write_m = m_q.mem_write;
    assign reg_write_w = w_q.reg_write;
    assign wb_sel_w    = w_q.wb_sel;
    assign wa_w        = w_q.reg_write ? w_q.wa : '0;

    assign unused_w = ^w_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus random instruction streams vs. a stage model.
module tb_pipe_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int NONE     = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d;
    logic        branch_d, jump_d, jr_d, link_d;
    logic [1:0]  ext_op_d;
    logic [2:0]  alu_op_e;
    logic        alu_src_e, md_start_e;
    logic [2:0]  md_op_e;
    logic        mem_write_m, reg_write_w;
    logic [1:0]  wb_sel_w;
    logic [4:0]  wa_w;
    logic        stall, md_busy;

    always #5 clk = ~clk;

    pipe_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d),
        .branch_d(branch_d), .jump_d(jump_d), .jr_d(jr_d), .link_d(link_d),
        .ext_op_d(ext_op_d), .alu_op_e(alu_op_e), .alu_src_e(alu_src_e),
        .md_start_e(md_start_e), .md_op_e(md_op_e), .mem_write_m(mem_write_m),
        .reg_write_w(reg_write_w), .wb_sel_w(wb_sel_w), .wa_w(wa_w),
        .stall(stall), .md_busy(md_busy)
    );

    typedef enum {I_BAD, I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_JR, I_MULT, I_MULTU,
                  I_DIV, I_DIVU, I_MFHI, I_MFLO, I_MTHI, I_MTLO, I_LW, I_SW, I_BEQ,
                  I_ORI, I_LUI, I_J, I_JAL} mn_t;

    typedef struct {
        bit wr; int wa; int rs; int rt; int tnew; int tuse_rs; int tuse_rt;
        bit md_any; bit md_start; int md_op; int alu_op; bit alu_src; bit mem_write;
        int wb_sel; bit branch; bit jump; bit jr; bit link; int ext_op;
    } op_t;

    int   checks = 0;
    int   failures = 0;
    op_t  st_e, st_m, st_w, bubble;
    int   busy_end;
    int   cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h instr=%08h t=%0t", tag, got, exp, instr_d, $time);
        end
    endtask

    function automatic logic [31:0] rtype(int fn, int rs, int rt, int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic mn_t classify(logic [31:0] i);
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h21: return I_ADDU;  6'h23: return I_SUBU;  6'h24: return I_AND;
                6'h25: return I_OR;    6'h2a: return I_SLT;   6'h08: return I_JR;
                6'h18: return I_MULT;  6'h19: return I_MULTU; 6'h1a: return I_DIV;
                6'h1b: return I_DIVU;  6'h10: return I_MFHI;  6'h12: return I_MFLO;
                6'h11: return I_MTHI;  6'h13: return I_MTLO;
                default: return I_BAD;
            endcase
        end
        case (op)
            6'h23: return I_LW;  6'h2b: return I_SW;  6'h04: return I_BEQ;
            6'h0d: return I_ORI; 6'h0f: return I_LUI; 6'h02: return I_J;
            6'h03: return I_JAL;
            default: return I_BAD;
        endcase
    endfunction

    // Per-instruction semantics straight from the instruction table
    function automatic op_t decode(logic [31:0] i);
        op_t r;
        int  dst = 0;
        mn_t m = classify(i);
        r = '{default: 0};
        r.rs = int'(i[25:21]);
        r.rt = int'(i[20:16]);
        r.tuse_rs = NONE;
        r.tuse_rt = NONE;
        case (m)
            I_ADDU, I_SUBU, I_AND, I_OR, I_SLT: begin
                r.wr = 1; dst = int'(i[15:11]); r.tnew = 1; r.tuse_rs = 1; r.tuse_rt = 1;
                r.alu_op = (m == I_ADDU) ? 2 : (m == I_SUBU) ? 6 : (m == I_AND) ? 0 : (m == I_OR) ? 1 : 7;
            end
            I_JR: begin r.jr = 1; r.tuse_rs = 0; end
            I_MULT, I_MULTU, I_DIV, I_DIVU: begin
                r.md_any = 1; r.md_start = 1; r.tuse_rs = 1; r.tuse_rt = 1;
                r.md_op = (m == I_MULT) ? 0 : (m == I_MULTU) ? 1 : (m == I_DIV) ? 2 : 3;
            end
            I_MTHI, I_MTLO: begin
                r.md_any = 1; r.md_start = 1; r.tuse_rs = 1; r.md_op = (m == I_MTHI) ? 4 : 5;
            end
            I_MFHI, I_MFLO: begin
                r.md_any = 1; r.wr = 1; dst = int'(i[15:11]); r.tnew = 1; r.wb_sel = 3;
            end
            I_LW: begin
                r.wr = 1; dst = r.rt; r.tnew = 2; r.alu_op = 2; r.alu_src = 1; r.ext_op = 1;
                r.wb_sel = 1; r.tuse_rs = 1;
            end
            I_SW: begin
                r.mem_write = 1; r.alu_op = 2; r.alu_src = 1; r.ext_op = 1;
                r.tuse_rs = 1; r.tuse_rt = 2;
            end
            I_BEQ: begin r.branch = 1; r.ext_op = 1; r.tuse_rs = 0; r.tuse_rt = 0; end
            I_ORI: begin
                r.wr = 1; dst = r.rt; r.tnew = 1; r.alu_op = 1; r.alu_src = 1; r.tuse_rs = 1;
            end
            I_LUI: begin
                r.wr = 1; dst = r.rt; r.tnew = 1; r.alu_op = 1; r.alu_src = 1; r.ext_op = 2;
            end
            I_J:   r.jump = 1;
            I_JAL: begin r.jump = 1; r.link = 1; r.wr = 1; dst = 31; r.wb_sel = 2; end
            default: ;
        endcase
        if (dst == 0) r.wr = 0;
        r.wa = r.wr ? dst : 0;
        return r;
    endfunction

    // A producer of age a (0 = E, 1 = M) has max(tnew - a, 0) cycles left
    function automatic bit raw(op_t d, op_t s, int age);
        int left = s.tnew - age;
        if (left < 0) left = 0;
        if (!s.wr || s.wa == 0) return 0;
        return (s.wa == d.rs && d.tuse_rs < left) || (s.wa == d.rt && d.tuse_rt < left);
    endfunction

    function automatic bit model_stall(op_t d);
        bit md = d.md_any && (cyc <= busy_end || st_e.md_start);
        return raw(d, st_e, 0) || raw(d, st_m, 1) || md;
    endfunction

    task automatic check_all(input op_t d, input bit es);
        check("stall",       32'(stall),       32'(es));
        check("branch_d",    32'(branch_d),    32'(d.branch));
        check("jump_d",      32'(jump_d),      32'(d.jump));
        check("jr_d",        32'(jr_d),        32'(d.jr));
        check("link_d",      32'(link_d),      32'(d.link));
        check("ext_op_d",    32'(ext_op_d),    32'(d.ext_op));
        check("alu_op_e",    32'(alu_op_e),    32'(st_e.alu_op));
        check("alu_src_e",   32'(alu_src_e),   32'(st_e.alu_src));
        check("md_start_e",  32'(md_start_e),  32'(st_e.md_start));
        check("md_op_e",     32'(md_op_e),     32'(st_e.md_op));
        check("mem_write_m", 32'(mem_write_m), 32'(st_m.mem_write));
        check("reg_write_w", 32'(reg_write_w), 32'(st_w.wr));
        check("wb_sel_w",    32'(wb_sel_w),    32'(st_w.wb_sel));
        check("wa_w",        32'(wa_w),        32'(st_w.wa));
        check("md_busy",     32'(md_busy),     32'(cyc <= busy_end));
    endtask

    // One clock with instr in D; returns model and observed stall
    task automatic step(input logic [31:0] instr, output bit es, output bit ds);
        op_t d;
        int  lat;
        @(negedge clk);
        instr_d = instr;
        #1;
        d  = decode(instr);
        es = model_stall(d);
        ds = stall;
        check_all(d, es);
        @(posedge clk);
        if (st_e.md_start) begin
            lat = (st_e.md_op <= 1) ? MULT_LAT : (st_e.md_op <= 3) ? DIV_LAT : 0;
            busy_end = cyc + lat;
        end
        st_w = st_m;
        st_m = st_e;
        st_e = es ? bubble : d;
        cyc++;
    endtask

    // Present instr until it leaves D; nstall counts observed stall cycles
    task automatic run(input logic [31:0] instr, output int nstall);
        bit es, ds, done;
        done   = 0;
        nstall = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(instr, es, ds);
            nstall += int'(ds);
            done = !es;
        end
        if (!done) check("run_bound", 32'(done), 32'(1));
    endtask

    task automatic drain();
        int n;
        for (int k = 0; k < 12; k++) run(32'h0, n);
    endtask

    task automatic model_reset();
        st_e = bubble;
        st_m = bubble;
        st_w = bubble;
        busy_end = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] ins;
        bubble = decode(32'h0);
        cyc = 0;
        model_reset();
        reset   = 1'b1;
        instr_d = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all(bubble, 1'b0);
        reset = 1'b0;

        // load-use: one bubble
        run(itype(6'h23, 0, 1, 0), n);
        run(rtype(6'h21, 1, 1, 2), n);
        check("lw_use_stalls", 32'(n), 32'(1));
        drain();

        // ALU result feeding a branch compare
        run(itype(6'h0d, 0, 3, 5), n);
        run(itype(6'h04, 3, 0, 4), n);
        check("ori_beq_stalls", 32'(n), 32'(1));
        drain();

        // mflo waits for the start cycle plus MULT_LAT busy cycles
        run(rtype(6'h18, 4, 5, 0), n);
        run(rtype(6'h12, 0, 0, 6), n);
        check("mult_mflo_stalls", 32'(n), 32'(1 + MULT_LAT));
        drain();

        // write to $0 never hazards and is dropped at W
        run(rtype(6'h21, 1, 2, 0), n);
        run(rtype(6'h21, 0, 0, 3), n);
        check("r0_dest_stalls", 32'(n), 32'(0));
        drain();

        // undefined opcode
        run(32'hFC00_0000, n);
        check("undef_stalls", 32'(n), 32'(0));
        drain();

        // reset in the middle of a divide
        run(rtype(6'h1a, 1, 2, 0), n);
        for (int k = 0; k < 3; k++) run(32'h0, n);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("md_busy_async_clear", 32'(md_busy), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        check_all(decode(instr_d), 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // random stream over a small register set to provoke hazards
        for (int t = 0; t < 300; t++) begin
            int k  = $urandom_range(0, 21);
            int ra = $urandom_range(0, 3);
            int rb = $urandom_range(0, 3);
            int rc = $urandom_range(0, 3);
            case (k)
                0:  ins = rtype(6'h21, ra, rb, rc);
                1:  ins = rtype(6'h23, ra, rb, rc);
                2:  ins = rtype(6'h24, ra, rb, rc);
                3:  ins = rtype(6'h25, ra, rb, rc);
                4:  ins = rtype(6'h2a, ra, rb, rc);
                5:  ins = rtype(6'h08, ra, 0, 0);
                6:  ins = rtype(6'h18 + $urandom_range(0, 3), ra, rb, 0);
                7:  ins = rtype(6'h10, 0, 0, rc);
                8:  ins = rtype(6'h12, 0, 0, rc);
                9:  ins = rtype(6'h11, ra, 0, 0);
                10: ins = rtype(6'h13, ra, 0, 0);
                11, 12: ins = itype(6'h23, ra, rb, $urandom_range(0, 255));
                13: ins = itype(6'h2b, ra, rb, $urandom_range(0, 255));
                14: ins = itype(6'h04, ra, rb, $urandom_range(0, 255));
                15: ins = itype(6'h0d, ra, rb, $urandom_range(0, 65535));
                16: ins = itype(6'h0f, 0, rb, $urandom_range(0, 65535));
                17: ins = {6'h02, 26'($urandom)};
                18: ins = {6'h03, 26'($urandom)};
                19: ins = 32'h0;
                20: ins = {6'h3f, 26'($urandom)};
                default: ins = $urandom;
            endcase
            run(ins, n);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipelined control unit for the five-stage MIPS core. It decodes the instruction held in the D stage into a control bundle and carries that bundle through registered E, M and W stage slots. It detects RAW hazards from per-instruction use/produce times and detects multiply/divide unit occupancy. It raises a single `stall` that freezes PC and the F/D register and injects a bubble into E.

## Interface
Parameters:
- `MULT_LAT`, default 5: busy cycles for mult/multu after issue in E.
- `DIV_LAT`, default 10: busy cycles for div/divu after issue in E.
- `CNT_W`, default 4: busy counter width. Requires `MULT_LAT`, `DIV_LAT` < 2^`CNT_W`.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instr_d` in 32: instruction in D stage.
- `branch_d`, `jump_d`, `jr_d`, `link_d` out 1 each: D-stage control flow (beq, j/jal, jr, jal).
- `ext_op_d` out 2: 00 zero-extend, 01 sign-extend, 10 lui shift.
- `alu_op_e` out 3: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `alu_src_e` out 1: 0 = rt, 1 = extended immediate.
- `md_start_e` out 1: pulse while a mult/div sits in E and E is not a bubble.
- `md_op_e` out 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
- `mem_write_m` out 1: sw in M.
- `reg_write_w` out 1.
- `wb_sel_w` out 2: 00 ALU, 01 memory, 10 PC+8, 11 HI/LO.
- `wa_w` out 5: write-back register. Forced to 0 whenever `reg_write_w`=0.
- `stall` out 1: hold PC and F/D, bubble E.
- `md_busy` out 1: busy counter non-zero.

## Operation
- Supported instructions: addu, subu, and, or, slt, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, lw, sw, beq, ori, lui, j, jal. Any other encoding, including sll $0 (nop), decodes to an all-zero bundle.
- Destination register: rd for R-type writes, rt for lw/ori/lui, 31 for jal. A destination of $0 clears the write-enable in the bundle.
- Use times (Tuse), counted in stages before the operand is needed:
  - beq rs/rt and jr rs: 0.
  - ALU operands, lw/sw base, and md source registers: 1.
  - sw rt: 2.
- Produce times (Tnew) at E entry:
  - lw: 2.
  - ALU ops and mfhi/mflo: 1.
  - jal: 0.
  - Tnew decrements by one per stage, floored at 0.
- Hazard stall: asserted when a D source with Tuse < Tnew of E or M matches that stage's write register, that register is non-zero, and that stage writes.
- Md stall: asserted when D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo and either `md_busy` or `md_start_e` is high.
- `stall` is the OR of the hazard stall and the md stall.
- Pipeline registers:
  - On stall, E loads the zero bundle; M and W advance normally.
  - Without stall, E loads the decoded D bundle.
  - M always loads E, and W always loads M.
- Busy counter:
  - When `md_start_e` is high with a mult type, load `MULT_LAT`. With a div type, load `DIV_LAT`. mthi/mtlo load 0.
  - Otherwise decrement while non-zero.

## Timing
- Decode outputs with the `_d` suffix are combinational from `instr_d`.
- Outputs with `_e`, `_m`, `_w` suffixes are driven from the stage registers, so a bundle appears 1, 2 and 3 cycles after leaving D.
- `stall` is combinational in the same cycle as the offending D instruction.
- Reset: all stage registers are cleared to the zero bundle and the counter to 0. All registered outputs therefore read 0 and `stall`=0. A reset mid-busy clears `md_busy` immediately, without waiting for the clock.
- `md_busy` rises the cycle after `md_start_e` and stays high for exactly LAT cycles.
- Simultaneous events:
  - When hazard stall and md stall coincide, a single stall is raised and the bubble count is the maximum of the two.
  - On the cycle the counter reaches 0, an md instruction waiting in D issues.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - opcode/funct constants;
  - alu_op, md_op and wb_sel encodings;
  - the control bundle struct;
  - the zero-bundle constant.
- One sub-module `pipe_decode` is natural: a purely combinational map from `instr_d` to the bundle plus Tuse_rs, Tuse_rt and Tnew.

## Test plan
- `lw $1,0($0)` then `addu $2,$1,$1`: `stall`=1 for exactly 1 cycle, and the E bubble has all outputs 0.
- `ori $3,$0,5` then `beq $3,$0,x`: 1-cycle stall. After the stall, `branch_d`=1.
- `mult $4,$5` then `mflo $6` with `MULT_LAT`=5: stall for 6 cycles total (1 for the `md_start_e` cycle plus 5 busy). `md_op_e`=000 during the start pulse.
- `addu $0,$1,$2` then `addu $3,$0,$0`: no stall, and `reg_write_w`=0 and `wa_w`=0 when the first instruction reaches W.
- `div` issued, then `reset` pulsed 3 cycles later: `md_busy`=0 immediately, and all `_e`, `_m`, `_w` outputs read 0 on the next edge.
- Undefined opcode 6'b111111: zero bundle, no stall, `reg_write_w`=0 three cycles later.
